// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU.
//   ALU_W    : default datapath width
//   alu_op_e : 3-bit operation encoding driven on ctrl
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_adder.sv
// Combinational adder with carry-in, shared by ADD, SUB and SLT.
//   a_i, b_i : operands (b_i is already inverted by the caller for subtraction)
//   cin_i    : carry-in (1 for subtraction)
//   sum_o    : modulo 2^WIDTH sum
//   cout_o   : carry out of the top bit
//   ovf_o    : two's-complement overflow of the addition
module alu_adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH:0] full_sum;

  always_comb begin
    full_sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    sum_o    = full_sum[WIDTH-1:0];
    cout_o   = full_sum[WIDTH];
    // Same-sign operands producing a differently-signed result.
    ovf_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
  end

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU for the execute stage. One operation per cycle,
// result and flags registered on the rising clock edge.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears all outputs
//   a, b  : operands
//   ctrl  : operation select (see alu_pkg::alu_op_e)
//   y     : registered result
//   cout  : registered carry-out (ADD carry, SUB/SLT no-borrow, 0 for logic ops)
//   ovf   : registered signed overflow, only when ALU_OVERFLOW_EN is defined
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
`ifdef ALU_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  alu_op_e op;
  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;
  logic             slt;

  logic [WIDTH-1:0] y_d, y_q;
  logic             cout_d, cout_q;
  logic             ovf_d;

  assign op     = alu_op_e'(ctrl);
  assign is_sub = (op == ALU_SUB) || (op == ALU_SLT);
  assign add_b  = is_sub ? ~b : b;

  alu_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i    (a),
    .b_i    (add_b),
    .cin_i  (is_sub),
    .sum_o  (add_sum),
    .cout_o (add_cout),
    .ovf_o  (add_ovf)
  );

  // Sign of the difference corrected for overflow gives the true signed compare.
  assign slt = add_sum[WIDTH-1] ^ add_ovf;

  always_comb begin
    y_d    = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    unique case (op)
      ALU_AND:  y_d = a & b;
      ALU_OR:   y_d = a | b;
      ALU_XOR:  y_d = a ^ b;
      ALU_ANDN: y_d = a & ~b;
      ALU_ORN:  y_d = a | ~b;
      ALU_ADD, ALU_SUB: begin
        y_d    = add_sum;
        cout_d = add_cout;
        ovf_d  = add_ovf;
      end
      ALU_SLT: begin
        y_d    = {{(WIDTH-1){1'b0}}, slt};
        cout_d = add_cout;
        ovf_d  = add_ovf;
      end
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      cout_q <= cout_d;
    end
  end

  assign y    = y_q;
  assign cout = cout_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_d;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed and randomized self-checking bench for alu.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ctrl;
  logic [31:0] y;
  logic        cout;
`ifdef ALU_OVERFLOW_EN
  logic        ovf;
`endif

  int n_pass;
  int n_total;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .ctrl  (ctrl),
`ifdef ALU_OVERFLOW_EN
    .ovf   (ovf),
`endif
    .y     (y),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, y} from plain 33-bit arithmetic and a signed compare.
  function automatic logic [32:0] ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                            input logic [2:0] rc);
    logic [32:0] s;
    logic        ge;
    ge = ({1'b0, ra} >= {1'b0, rb});
    case (rc)
      3'd0: s = {1'b0, ra & rb};
      3'd1: s = {1'b0, ra | rb};
      3'd2: s = {1'b0, ra} + {1'b0, rb};
      3'd3: s = {1'b0, ra ^ rb};
      3'd4: s = {1'b0, ra & ~rb};
      3'd5: s = {1'b0, ra | ~rb};
      3'd6: s = {ge, ra - rb};
      default: s = {ge, 31'd0, ($signed(ra) < $signed(rb))};
    endcase
    return s;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] ra, input logic [31:0] rb,
                                   input logic [2:0] rc);
    logic signed [32:0] full;
    logic [31:0]        r;
    case (rc)
      3'd2: begin
        full = $signed({ra[31], ra}) + $signed({rb[31], rb});
        r    = ra + rb;
        return full != $signed({r[31], r});
      end
      3'd6, 3'd7: begin
        full = $signed({ra[31], ra}) - $signed({rb[31], rb});
        r    = ra - rb;
        return full != $signed({r[31], r});
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tc);
    a    = ta;
    b    = tb;
    ctrl = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a = 32'd16; b = 32'd3; ctrl = 3'b010;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (y !== 32'd0 || cout !== 1'b0)
      $display("FAIL reset_async y=%h cout=%b required y=0 cout=0", y, cout);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (y !== 32'd0) $display("FAIL reset_hold y=%h required 0", y);
    else n_pass++;
`ifdef ALU_OVERFLOW_EN
    n_total++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf ovf=%b required 0", ovf);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'd16, 32'd3, 3'b010);
    n_total++;
    if (y !== 32'd19 || cout !== 1'b0)
      $display("FAIL reset_first_add y=%0d cout=%b required y=19 cout=0", y, cout);
    else n_pass++;
    // Mid-cycle assert: outputs must clear without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (y !== 32'd0 || cout !== 1'b0)
      $display("FAIL reset_midcycle y=%h cout=%b required y=0 cout=0", y, cout);
    else n_pass++;
    #2 rst_n = 1'b1;
    apply(32'd5, 32'd3, 3'b011);
    n_total++;
    if (y !== 32'd6 || cout !== 1'b0)
      $display("FAIL reset_release y=%0d cout=%b required y=6 cout=0", y, cout);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [31:0] ey [8];
    logic        ec [8];
    ey = '{32'd0, 32'd19, 32'd19, 32'd19, 32'd16, 32'hFFFFFFFC, 32'd13, 32'd0};
    ec = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      apply(32'd16, 32'd3, 3'(i));
      n_total++;
      if (y !== ey[i] || cout !== ec[i])
        $display("FAIL sweep_ctrl%0d y=%h cout=%b required y=%h cout=%b",
                 i, y, cout, ey[i], ec[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    apply(32'hFFFFFFFF, 32'd1, 3'b010);
    n_total++;
    if (y !== 32'd0 || cout !== 1'b1)
      $display("FAIL wrap_add y=%h cout=%b required y=0 cout=1", y, cout);
    else n_pass++;
    apply(32'h7FFFFFFF, 32'd1, 3'b010);
    n_total++;
    if (y !== 32'h80000000 || cout !== 1'b0)
      $display("FAIL wrap_signed y=%h cout=%b required y=80000000 cout=0", y, cout);
    else n_pass++;
`ifdef ALU_OVERFLOW_EN
    n_total++;
    if (ovf !== 1'b1) $display("FAIL wrap_ovf ovf=%b required 1", ovf);
    else n_pass++;
`endif
  endtask

  task automatic test_borrow();
    apply(32'd3, 32'd16, 3'b110);
    n_total++;
    if (y !== 32'hFFFFFFF3 || cout !== 1'b0)
      $display("FAIL borrow_sub y=%h cout=%b required y=fffffff3 cout=0", y, cout);
    else n_pass++;
    apply(32'd3, 32'd16, 3'b111);
    n_total++;
    if (y !== 32'd1 || cout !== 1'b0)
      $display("FAIL borrow_slt y=%h cout=%b required y=1 cout=0", y, cout);
    else n_pass++;
  endtask

  task automatic test_slt_signed();
    apply(32'h80000000, 32'd1, 3'b111);
    n_total++;
    if (y !== 32'd1 || cout !== 1'b1)
      $display("FAIL slt_min_lt_1 y=%h cout=%b required y=1 cout=1", y, cout);
    else n_pass++;
`ifdef ALU_OVERFLOW_EN
    n_total++;
    if (ovf !== 1'b1) $display("FAIL slt_min_ovf ovf=%b required 1", ovf);
    else n_pass++;
`endif
    apply(32'd1, 32'h80000000, 3'b111);
    n_total++;
    if (y !== 32'd0 || cout !== 1'b0)
      $display("FAIL slt_1_lt_min y=%h cout=%b required y=0 cout=0", y, cout);
    else n_pass++;
    apply(32'd5, 32'd5, 3'b111);
    n_total++;
    if (y !== 32'd0 || cout !== 1'b1)
      $display("FAIL slt_equal y=%h cout=%b required y=0 cout=1", y, cout);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  c;
    logic [31:0] ra, rb;
    logic [32:0] exp;
    int          errs;
    c    = 3'd0;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      // Bias toward operand extremes so carry and overflow paths are hit.
      if ((i % 16) == 3) ra = 32'h7FFFFFFF;
      if ((i % 16) == 7) rb = 32'h80000000;
      c   = c + 3'($urandom_range(1, 7));
      exp = ref_model(ra, rb, c);
      apply(ra, rb, c);
      n_total++;
      if (y !== exp[31:0] || cout !== exp[32]) begin
        if (errs < 10)
          $display("FAIL b2b_%0d ctrl=%0d a=%h b=%h y=%h cout=%b required y=%h cout=%b",
                   i, c, ra, rb, y, cout, exp[31:0], exp[32]);
        errs++;
      end else n_pass++;
`ifdef ALU_OVERFLOW_EN
      n_total++;
      if (ovf !== ref_ovf(ra, rb, c)) begin
        if (errs < 10)
          $display("FAIL b2b_ovf_%0d ctrl=%0d a=%h b=%h ovf=%b required %b",
                   i, c, ra, rb, ovf, ref_ovf(ra, rb, c));
        errs++;
      end else n_pass++;
`endif
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_sweep();
    test_wrap();
    test_borrow();
    test_slt_signed();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit registered arithmetic/logic unit for the datapath execute stage.
- Combinationally computes one of eight operations on operands a and b, selected by the 3-bit ctrl.
- Registers the result and carry-out on the rising clock edge.
- Purely functional: no handshake, no internal state beyond the output registers.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is required to be supported; all values below assume 32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  32  operand A
- b  input  32  operand B
- ctrl  input  3  operation select
- y  output  32  registered result
- cout  output  1  registered carry-out
- ovf  output  1  registered signed overflow; present only with ALU_OVERFLOW_EN

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, y=0, cout=0 and ovf=0 immediately, independent of clk.
- Latency: inputs sampled at rising clk edge; y/cout/ovf valid after that same edge (1-cycle latency). New op accepted every cycle.
- Reset deasserting mid-operation: first capture happens at the first rising edge with rst_n=1. No result is carried over from before reset.
- ctrl encoding:
  - 000 AND: y = a & b
  - 001 OR: y = a | b
  - 010 ADD: y = a + b
  - 011 XOR: y = a ^ b
  - 100 ANDN: y = a & ~b
  - 101 ORN: y = a | ~b
  - 110 SUB: y = a + ~b + 1
  - 111 SLT: y = 1 if signed(a) < signed(b), else 0
- Carry rules:
  - ADD: cout = bit 32 of the 33-bit sum a+b.
  - SUB and SLT: cout = bit 32 of a + ~b + 1. cout=1 means no borrow, i.e. a >= b unsigned.
  - Logic ops (000, 001, 011, 100, 101): cout = 0.
- SLT: uses the signed comparison, i.e. (sub_result[31] XOR signed overflow). It stays correct when the subtraction overflows. Upper 31 bits of y are 0.
- Wrap-around: ADD/SUB results are modulo 2^32. For example, 0xFFFFFFFF + 1 gives y=0, cout=1.
- All ctrl values are defined; no X output for any input combination.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: port ovf exists, registered and reset like cout.
  - ADD: ovf = (a[31]==b[31]) && (y[31]!=a[31]).
  - SUB/SLT: ovf = (a[31]!=b[31]) && (diff[31]!=a[31]).
  - All other ops: ovf = 0.
- Not defined: ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - localparam ALU_W = 32
  - enum alu_op_e: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_XOR=3'b011, ALU_ANDN=3'b100, ALU_ORN=3'b101, ALU_SUB=3'b110, ALU_SLT=3'b111
- Sub-module alu_adder: 32-bit adder with carry-in, producing sum, carry-out and overflow.
  - Shared by ADD (cin=0, operand b).
  - Shared by SUB/SLT (cin=1, operand ~b).
- Top level: operand mux, logic ops, result mux and output registers.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> y=0, cout=0 immediately; release, apply a=16, b=3, ctrl=010 -> y=19 one edge later.
- Sweep ctrl 0..7 with a=16, b=3 (one op per cycle), expected results:
  - 000 -> y=0, cout=0
  - 001 -> y=19, cout=0
  - 010 -> y=19, cout=0
  - 011 -> y=19, cout=0
  - 100 -> y=16, cout=0
  - 101 -> y=0xFFFFFFFC, cout=0
  - 110 -> y=13, cout=1
  - 111 -> y=0, cout=1
- Wrap: a=0xFFFFFFFF, b=1, ADD -> y=0, cout=1. With ALU_OVERFLOW_EN, a=0x7FFFFFFF, b=1 -> y=0x80000000, ovf=1.
- Borrow: a=3, b=16, SUB -> y=0xFFFFFFF3, cout=0; SLT -> y=1.
- Signed SLT across overflow: a=0x80000000, b=1 -> y=1; a=1, b=0x80000000 -> y=0; a=b=5 -> y=0, cout=1.
- Back-to-back: change ctrl every cycle with random a/b for 1000 cycles -> y/cout match a reference model delayed by exactly one cycle.
